// File: rtl/reverb_wet_mixer.sv
// -----------------------------------------------------------------------------
// reverb_wet_mixer
//
// Output stage that sits directly after the FDN reverb. The dry input and the
// reverb wet output are crossfaded with a mix weight that slews one step at a
// time, so target changes do not cause zipper noise. Makeup gain, rounding and
// 16-bit saturation follow. A sticky clip flag and a decaying peak meter
// report on the output for the audio loopback path.
//
// Datapath: four register stages, one sample per clock, latency 4.
//   S1  capture dry, wet, gain and the current mix weight m
//   S2  acc  = dry*(32-m) + wet*m           (signed 22 bit, cannot overflow)
//   S3  prod = acc * gain                   (signed 28 bit, gain is Q3.2)
//   S4  r    = (prod + 64) >>> 7, saturate  (the 7-bit shift removes the
//                                            5-bit weight scale and the
//                                            2-bit gain fraction)
//
// Parameters
//   RAMP_DIV   accepted samples per one-step change of the mix weight (>=1)
//   PEAK_HOLD  output samples without a new peak before one decay step (>=1)
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   sample_valid  in   qualifies dry_in / wet_in / out_gain this cycle
//   dry_in        in   signed 16-bit dry sample
//   wet_in        in   signed 16-bit wet sample
//   mix_target    in   requested wet weight 0..32, larger values act as 32
//   bypass        in   forces the effective target to 0 (ramps to dry)
//   out_gain      in   unsigned Q3.2 makeup gain (4 = unity)
//   clip_clr      in   single-cycle pulse clearing clip_flag
//   audio_out     out  signed 16-bit mixed output, held between samples
//   out_valid     out  single-cycle pulse per output sample
//   clip_flag     out  sticky saturation indicator
//   peak_level    out  decaying peak of |audio_out|
// -----------------------------------------------------------------------------
module reverb_wet_mixer #(
    parameter int RAMP_DIV  = 64,
    parameter int PEAK_HOLD = 4800
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_valid,
    input  logic signed [15:0] dry_in,
    input  logic signed [15:0] wet_in,
    input  logic [5:0]         mix_target,
    input  logic               bypass,
    input  logic [4:0]         out_gain,
    input  logic               clip_clr,
    output logic signed [15:0] audio_out,
    output logic               out_valid,
    output logic               clip_flag,
    output logic [14:0]        peak_level
);

    localparam int RC_W = (RAMP_DIV  > 1) ? $clog2(RAMP_DIV)  : 1;
    localparam int HC_W = (PEAK_HOLD > 1) ? $clog2(PEAK_HOLD) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RAMP_DIV - 1);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(PEAK_HOLD - 1);

    // -------------------------------------------------------------------------
    // Mix weight ramp
    // -------------------------------------------------------------------------
    logic [5:0]      w_tgt;
    logic [5:0]      r_mix_cur;
    logic [RC_W-1:0] r_ramp_cnt;

    always_comb begin
        w_tgt = 6'd0;
        if (!bypass) begin
            w_tgt = (mix_target > 6'd32) ? 6'd32 : mix_target;
        end
    end

    // The counter is not cleared on a target change, so a redirected ramp
    // keeps its cadence. Because w_tgt is clamped to 0..32 and the weight only
    // moves toward it, r_mix_cur can never leave that range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mix_cur  <= 6'd0;
            r_ramp_cnt <= '0;
        end else if (sample_valid) begin
            if (r_mix_cur == w_tgt) begin
                r_ramp_cnt <= '0;
            end else if (r_ramp_cnt == RC_LAST) begin
                r_mix_cur  <= (r_mix_cur < w_tgt) ? r_mix_cur + 6'd1
                                                  : r_mix_cur - 6'd1;
                r_ramp_cnt <= '0;
            end else begin
                r_ramp_cnt <= r_ramp_cnt + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // S1: capture inputs together with the weight in force before this
    // sample's ramp update.
    // -------------------------------------------------------------------------
    logic               r_s1_valid;
    logic signed [15:0] r_s1_dry;
    logic signed [15:0] r_s1_wet;
    logic [4:0]         r_s1_gain;
    logic [5:0]         r_s1_mix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_dry   <= '0;
            r_s1_wet   <= '0;
            r_s1_gain  <= '0;
            r_s1_mix   <= '0;
        end else begin
            r_s1_valid <= sample_valid;
            if (sample_valid) begin
                r_s1_dry  <= dry_in;
                r_s1_wet  <= wet_in;
                r_s1_gain <= out_gain;
                r_s1_mix  <= r_mix_cur;
            end
        end
    end

    // -------------------------------------------------------------------------
    // S2: crossfade. Weights are zero-extended so they multiply as positive
    // signed values; each term is at most 2^20 in magnitude.
    // -------------------------------------------------------------------------
    logic [5:0]         w_dry_wt;
    logic signed [21:0] w_dry_term;
    logic signed [21:0] w_wet_term;
    logic               r_s2_valid;
    logic signed [21:0] r_s2_acc;
    logic [4:0]         r_s2_gain;

    assign w_dry_wt   = 6'd32 - r_s1_mix;
    assign w_dry_term = r_s1_dry * $signed({1'b0, w_dry_wt});
    assign w_wet_term = r_s1_wet * $signed({1'b0, r_s1_mix});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_acc   <= '0;
            r_s2_gain  <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_acc   <= w_dry_term + w_wet_term;
            r_s2_gain  <= r_s1_gain;
        end
    end

    // -------------------------------------------------------------------------
    // S3: makeup gain
    // -------------------------------------------------------------------------
    logic signed [27:0] w_prod;
    logic               r_s3_valid;
    logic signed [27:0] r_s3_prod;

    assign w_prod = r_s2_acc * $signed({1'b0, r_s2_gain});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_valid <= 1'b0;
            r_s3_prod  <= '0;
        end else begin
            r_s3_valid <= r_s2_valid;
            r_s3_prod  <= w_prod;
        end
    end

    // -------------------------------------------------------------------------
    // S4: round half up, saturate, output register and clip flag
    // -------------------------------------------------------------------------
    logic signed [27:0] w_round;
    logic signed [27:0] w_shift;
    logic               w_sat_hi;
    logic               w_sat_lo;
    logic signed [15:0] w_s4_out;
    logic signed [15:0] r_audio_out;
    logic               r_out_valid;
    logic               r_clip_flag;

    // |prod| stays below 2^26, so adding the rounding constant cannot wrap.
    assign w_round  = r_s3_prod + 28'sd64;
    assign w_shift  = w_round >>> 7;
    assign w_sat_hi = (w_shift > 28'sd32767);
    assign w_sat_lo = (w_shift < -28'sd32768);

    always_comb begin
        w_s4_out = w_shift[15:0];
        if (w_sat_hi) begin
            w_s4_out = 16'sh7fff;
        end else if (w_sat_lo) begin
            w_s4_out = 16'sh8000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_audio_out <= '0;
        end else begin
            r_out_valid <= r_s3_valid;
            if (r_s3_valid) begin
                r_audio_out <= w_s4_out;
            end
        end
    end

    // A new saturation outranks a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clip_flag <= 1'b0;
        end else if (r_s3_valid && (w_sat_hi || w_sat_lo)) begin
            r_clip_flag <= 1'b1;
        end else if (clip_clr) begin
            r_clip_flag <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Peak meter, fed from the registered output while out_valid is high.
    // -------------------------------------------------------------------------
    logic [15:0]     w_mag;
    logic [14:0]     w_abs;
    logic [14:0]     w_peak_dec;
    logic [14:0]     r_peak_level;
    logic [HC_W-1:0] r_hold_cnt;

    // Negating -32768 leaves bit 15 set; that single case maps to 32767.
    assign w_mag      = r_audio_out[15] ? 16'(-r_audio_out) : r_audio_out;
    assign w_abs      = w_mag[15] ? 15'h7fff : w_mag[14:0];
    assign w_peak_dec = r_peak_level - {4'b0000, r_peak_level[14:4]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_peak_level <= '0;
            r_hold_cnt   <= '0;
        end else if (r_out_valid) begin
            if (w_abs >= r_peak_level) begin
                r_peak_level <= w_abs;
                r_hold_cnt   <= '0;
            end else if (r_hold_cnt == HC_LAST) begin
                r_peak_level <= w_peak_dec;
                r_hold_cnt   <= '0;
            end else begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    assign audio_out  = r_audio_out;
    assign out_valid  = r_out_valid;
    assign clip_flag  = r_clip_flag;
    assign peak_level = r_peak_level;

endmodule
